// File: rtl/dpram_arbiter.sv
// Round-robin arbiter that maps up to two requesters per cycle onto the A/B
// ports of a true dual-port RAM and steers 1-cycle-late read data back.
module dpram_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr_a,
  output logic [ADDR_WIDTH-1:0]         ram_addr_b,
  output logic [DATA_WIDTH-1:0]         ram_wdata_a,
  output logic [DATA_WIDTH-1:0]         ram_wdata_b,
  output logic                          ram_we_a,
  output logic                          ram_we_b,
  input  logic [DATA_WIDTH-1:0]         ram_q_a,
  input  logic [DATA_WIDTH-1:0]         ram_q_b
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SW    = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic [NUM_REQ-1:0] sel_b_reg, sel_b_next;

  logic             a_found, b_found;
  logic [PTR_W-1:0] a_idx, b_idx, scan_idx, last_idx;
  logic [SW-1:0]    scan_ext;
  logic             grant_a, grant_b;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
        rsp_valid_reg[gi] ? (sel_b_reg[gi] ? ram_q_b : ram_q_a) : '0;
    end
  endgenerate

  // Scan from rr_ptr; port B skips any candidate that would race port A's
  // access to the same word with a write involved.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_ext = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_ext = {1'b0, rr_ptr_reg} + SW'(k);
      if (scan_ext >= SW'(NUM_REQ)) scan_ext = scan_ext - SW'(NUM_REQ);
      scan_idx = scan_ext[PTR_W-1:0];
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found &&
                     !((addr_arr[scan_idx] == addr_arr[a_idx]) &&
                       (req_we[scan_idx] || req_we[a_idx]))) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
  end

  // Reset also masks grants so the block looks idle while rst_n is low.
  assign grant_a = rst_n & a_found;
  assign grant_b = rst_n & b_found;

  always_comb begin
    ram_addr_a  = '0;
    ram_wdata_a = '0;
    ram_we_a    = 1'b0;
    ram_addr_b  = '0;
    ram_wdata_b = '0;
    ram_we_b    = 1'b0;
    if (grant_a) begin
      ram_addr_a  = addr_arr[a_idx];
      ram_wdata_a = wdata_arr[a_idx];
      ram_we_a    = req_we[a_idx];
    end
    if (grant_b) begin
      ram_addr_b  = addr_arr[b_idx];
      ram_wdata_b = wdata_arr[b_idx];
      ram_we_b    = req_we[b_idx];
    end
  end

  always_comb begin
    req_ready  = '0;
    sel_b_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((grant_a && a_idx == PTR_W'(i)) || (grant_b && b_idx == PTR_W'(i)))
        req_ready[i] = 1'b1;
      if (grant_b && b_idx == PTR_W'(i))
        sel_b_next[i] = 1'b1;
    end
  end

  assign rsp_valid_next = req_ready & req_valid & ~req_we;
  assign rsp_valid      = rsp_valid_reg;

  always_comb begin
    last_idx    = grant_b ? b_idx : a_idx;
    rr_ptr_next = rr_ptr_reg;
    if (grant_a)
      rr_ptr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= '0;
      sel_b_reg     <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      rsp_valid_reg <= rsp_valid_next;
      sel_b_reg     <= sel_b_next;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Randomised and directed bench for dpram_arbiter, comparing every cycle
// against a queue-free behavioural model of arbitration and RAM contents.
module tb_dpram_arbiter;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [NR*DW-1:0] rsp_rdata;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [DW-1:0]    ram_wdata_a, ram_wdata_b;
  logic             ram_we_a, ram_we_b;
  logic [DW-1:0]    ram_q_a = '0;
  logic [DW-1:0]    ram_q_b = '0;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // True dual-port RAM, write-first per port, 1-cycle read latency.
  logic [DW-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we_a) begin mem[ram_addr_a] <= ram_wdata_a; ram_q_a <= ram_wdata_a; end
    else ram_q_a <= mem[ram_addr_a];
    if (ram_we_b) begin mem[ram_addr_b] <= ram_wdata_b; ram_q_b <= ram_wdata_b; end
    else ram_q_b <= mem[ram_addr_b];
  end

  // Reference state and counters, owned by the compare process.
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  logic [DW-1:0] mmem [16] = '{default: '0};
  logic [NR-1:0] exp_v = '0;
  logic [DW-1:0] exp_d [NR] = '{default: '0};
  int wait_cnt [NR] = '{default: 0};

  // Hand-computed expectations, owned by the stimulus process.
  logic          lit_ready_en, lit_ptr_en, lit_rspv_en, fair_en;
  logic [NR-1:0] lit_ready, lit_rspv, lit_rsp_mask, acc;
  logic [DW-1:0] lit_rsp_d;
  int            lit_ptr;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int ga, gb, j;
    logic [NR-1:0] er;
    logic [AW-1:0] ea_addr, eb_addr;
    logic [DW-1:0] ea_wd, eb_wd;
    logic ea_we, eb_we;
    if (!rst_n) begin
      check("rst_ready", DW'(req_ready), '0);
      check("rst_rsp_valid", DW'(rsp_valid), '0);
      for (int i = 0; i < NR; i++)
        check($sformatf("rst_rdata%0d", i), rsp_rdata[i*DW +: DW], '0);
      check("rst_addr_a", DW'(ram_addr_a), '0);
      check("rst_addr_b", DW'(ram_addr_b), '0);
      check("rst_we", DW'({ram_we_a, ram_we_b}), '0);
      check("rst_wdata", ram_wdata_a | ram_wdata_b, '0);
      check("rst_ptr", DW'(dut.rr_ptr_reg), '0);
      mptr  = 0;
      exp_v = '0;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      ga = -1; gb = -1;
      for (int k = 0; k < NR; k++) begin
        j = (mptr + k) % NR;
        if (req_valid[j]) begin
          if (ga < 0) ga = j;
          else if (gb < 0 && !(req_addr[j*AW +: AW] == req_addr[ga*AW +: AW] &&
                               (req_we[j] || req_we[ga]))) gb = j;
        end
      end
      er = '0; ea_addr = '0; eb_addr = '0; ea_wd = '0; eb_wd = '0; ea_we = 0; eb_we = 0;
      if (ga >= 0) begin
        er[ga] = 1'b1; ea_addr = req_addr[ga*AW +: AW]; ea_wd = req_wdata[ga*DW +: DW]; ea_we = req_we[ga];
      end
      if (gb >= 0) begin
        er[gb] = 1'b1; eb_addr = req_addr[gb*AW +: AW]; eb_wd = req_wdata[gb*DW +: DW]; eb_we = req_we[gb];
      end
      check("ready", DW'(req_ready), DW'(er));
      check("addr_a", DW'(ram_addr_a), DW'(ea_addr));
      check("addr_b", DW'(ram_addr_b), DW'(eb_addr));
      check("wdata_a", ram_wdata_a, ea_wd);
      check("wdata_b", ram_wdata_b, eb_wd);
      check("we_a", DW'(ram_we_a), DW'(ea_we));
      check("we_b", DW'(ram_we_b), DW'(eb_we));
      check("rsp_valid", DW'(rsp_valid), DW'(exp_v));
      for (int i = 0; i < NR; i++)
        check($sformatf("rdata%0d", i), rsp_rdata[i*DW +: DW], exp_v[i] ? exp_d[i] : '0);
      check("rr_ptr", DW'(dut.rr_ptr_reg), DW'(mptr));

      if (lit_ready_en) begin
        check("lit_ready", DW'(req_ready), DW'(lit_ready));
        check("model_ready", DW'(er), DW'(lit_ready));
      end
      if (lit_ptr_en)  check("lit_ptr", DW'(dut.rr_ptr_reg), DW'(lit_ptr));
      if (lit_rspv_en) check("lit_rsp_valid", DW'(rsp_valid), DW'(lit_rspv));
      for (int i = 0; i < NR; i++)
        if (lit_rsp_mask[i]) check($sformatf("lit_rdata%0d", i), rsp_rdata[i*DW +: DW], lit_rsp_d);

      // Fairness: a pending request must be granted by its second cycle.
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !req_ready[i]) wait_cnt[i]++;
        else begin
          if (req_valid[i] && fair_en) begin
            checks++;
            if (wait_cnt[i] + 1 > 2) begin
              errors++;
              $display("FAIL wait%0d: got %0d cycles want <= 2", i, wait_cnt[i] + 1);
            end
          end
          wait_cnt[i] = 0;
        end
      end

      exp_v = '0;
      for (int i = 0; i < NR; i++)
        if (er[i] && !req_we[i]) begin
          exp_v[i] = 1'b1;
          exp_d[i] = mmem[req_addr[i*AW +: AW]];
        end
      for (int i = 0; i < NR; i++)
        if (er[i] && req_we[i]) mmem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
      if (gb >= 0) mptr = (gb + 1) % NR;
      else if (ga >= 0) mptr = (ga + 1) % NR;
    end
  end

  task automatic clr_lits();
    lit_ready_en = 0; lit_ptr_en = 0; lit_rspv_en = 0; lit_rsp_mask = '0;
  endtask
  task automatic settle();
    @(negedge clk); #1;
    acc = req_valid & req_ready;
    clr_lits();
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic put(input int i, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v; req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask
  task automatic want_ready(input logic [NR-1:0] r);
    lit_ready_en = 1; lit_ready = r;
  endtask
  task automatic want_rsp(input logic [NR-1:0] m, input logic [DW-1:0] d);
    lit_rspv_en = 1; lit_rspv = m; lit_rsp_mask = m; lit_rsp_d = d;
  endtask
  task automatic drain();
    repeat (8) begin tick(); req_valid = req_valid & ~acc; settle(); end
  endtask
  task automatic rand_phase(input int cycles, input bit reads_only, input int pct);
    repeat (cycles) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (!(req_valid[i] && !acc[i])) begin
          if ($urandom_range(0, 99) < pct)
            put(i, 1, reads_only ? 1'b0 : 1'($urandom_range(0, 1)),
                AW'(reads_only ? $urandom_range(0, 15) : $urandom_range(0, 3)),
                {$urandom, $urandom});
          else req_valid[i] = 1'b0;
        end
      settle();
    end
  endtask

  initial begin
    rst_n = 0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    fair_en = 0; acc = '0; lit_ready = '0; lit_rspv = '0; lit_rsp_d = '0; lit_ptr = 0;
    clr_lits();
    repeat (3) @(posedge clk);
    #1;
    // All four read distinct addresses straight out of reset.
    rst_n = 1;
    for (int i = 0; i < NR; i++) put(i, 1, 0, AW'(i), '0);
    want_ready(4'b0011); lit_ptr_en = 1; lit_ptr = 0;
    settle();
    tick(); req_valid = 4'b1100; want_ready(4'b1100); lit_ptr_en = 1; lit_ptr = 2; settle();
    tick(); req_valid = '0; want_ready(4'b0000); lit_ptr_en = 1; lit_ptr = 0; settle();
    // Write then read back through requester 2.
    tick(); put(2, 1, 1, 4'd5, 64'h0000_0000_DEAD_BEEF); want_ready(4'b0100); settle();
    tick(); put(2, 1, 0, 4'd5, '0); want_ready(4'b0100); settle();
    tick(); req_valid = '0; want_rsp(4'b0100, 64'h0000_0000_DEAD_BEEF); settle();
    // Same-address write/read collision: the read waits one cycle.
    tick(); put(0, 1, 1, 4'd3, 64'h1234_5678_9ABC_DEF0); put(1, 1, 0, 4'd3, '0);
    want_ready(4'b0001); settle();
    tick(); req_valid[0] = 1'b0; want_ready(4'b0010); lit_ptr_en = 1; lit_ptr = 1; settle();
    tick(); req_valid = '0; want_rsp(4'b0010, 64'h1234_5678_9ABC_DEF0); settle();
    // Two readers of one address share the cycle.
    tick(); put(0, 1, 1, 4'd7, 64'hA5A5_0F0F_C3C3_7E7E); want_ready(4'b0001); settle();
    tick(); req_valid = '0; put(1, 1, 0, 4'd7, '0); put(3, 1, 0, 4'd7, '0); want_ready(4'b1010); settle();
    tick(); req_valid = '0; want_rsp(4'b1010, 64'hA5A5_0F0F_C3C3_7E7E); settle();
    // Requester 1 streams reads while the others arrive sparsely.
    fair_en = 1;
    repeat (40) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (!(req_valid[i] && !acc[i])) begin
          if (i == 1) put(1, 1, 0, AW'($urandom_range(0, 15)), '0);
          else put(i, $urandom_range(0, 3) == 0, 0, AW'($urandom_range(0, 15)), '0);
        end
      settle();
    end
    drain();
    fair_en = 0;
    // Reset lands after a read is granted but before the clock edge.
    tick(); req_valid = '0; put(2, 1, 0, 4'd9, '0); want_ready(4'b0100); settle();
    #1; rst_n = 0; req_valid = '0;
    @(negedge clk);
    @(posedge clk); #2; rst_n = 1;
    lit_rspv_en = 1; lit_rspv = '0; lit_ptr_en = 1; lit_ptr = 0;
    for (int i = 0; i < NR; i++) put(i, 1, 0, AW'(i + 8), '0);
    want_ready(4'b0011);
    settle();
    tick(); req_valid = req_valid & ~acc; want_ready(4'b1100); settle();
    tick(); req_valid = '0; settle();
    // Mixed random traffic with deliberate address collisions, then reads only.
    rand_phase(300, 1'b0, 60);
    drain();
    fair_en = 1;
    rand_phase(150, 1'b1, 80);
    drain();
    fair_en = 0;
    tick(); req_valid = '0; settle();
    tick(); settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the word width of RAM data and requester data.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the RAM word-address width.
REQ-003 Parameter NUM_REQ, default 4, fixed range 2..8, SHALL set the requester count. Requester i SHALL occupy bit i, or slice i of each flattened bus.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed:
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous active-low reset
REQ-005 Requester ports SHALL be:
- req_valid  in  NUM_REQ  request pending
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data
- req_ready  out  NUM_REQ  request accepted this cycle
- rsp_valid  out  NUM_REQ  read data valid
- rsp_rdata  out  NUM_REQ*DATA_WIDTH  read data
REQ-006 RAM-side ports, toward a single-clock true dual-port RAM with 1-cycle read latency and write-first per port, SHALL be:
- ram_addr_a, ram_addr_b  out  ADDR_WIDTH each
- ram_wdata_a, ram_wdata_b  out  DATA_WIDTH each
- ram_we_a, ram_we_b  out  1 each
- ram_q_a, ram_q_b  in  DATA_WIDTH each

Function
REQ-007 Each cycle, the block SHALL scan requesters in round-robin order, starting at pointer rr_ptr and wrapping modulo NUM_REQ. It SHALL grant at most two requests:
- first found requester -> port A
- second found requester -> port B
REQ-008 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high. req_ready is combinational from the current inputs and rr_ptr. A requester SHALL hold valid/we/addr/wdata stable until accepted.
REQ-009 Conflict rule: if the second candidate has the same address as the port-A grant, and either of the two is a write, the second SHALL NOT be granted this cycle. The scan SHALL continue to the next eligible requester for port B.
REQ-010 An ungranted port SHALL drive addr = 0, wdata = 0, we = 0.
REQ-011 A granted port SHALL drive addr, wdata and we of its requester in the same cycle, with no added register stage.
REQ-012 On any cycle with at least one grant, rr_ptr SHALL become (index of the last granted requester + 1) mod NUM_REQ. With no grant, rr_ptr SHALL hold.
REQ-013 A write SHALL be complete at acceptance. Writes SHALL produce no response.
REQ-014 A read accepted in cycle N SHALL produce rsp_valid[i] = 1 for exactly cycle N+1. rsp_rdata slice i SHALL equal ram_q of the port used in cycle N.
- The port used SHALL be recorded in a registered per-requester select bit.
REQ-015 When rsp_valid[i] = 0, rsp_rdata slice i SHALL be 0.
REQ-016 A requester MAY issue back-to-back reads in consecutive cycles. Responses SHALL follow in consecutive cycles, in order.
REQ-017 When all requests present are mutually compatible and NUM_REQ requests are pending, every requester SHALL be granted within ceil(NUM_REQ/2) cycles.
REQ-018 Read-to-read on the same address SHALL be allowed on both ports in the same cycle.

Reset
REQ-019 While rst_n = 0, asynchronously:
- rr_ptr = 0
- all response-pipeline valid bits = 0
- all port-select bits = 0
REQ-020 During reset, the outputs SHALL be: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, RAM ports idle per REQ-010.
REQ-021 A read accepted in the cycle before reset asserts SHALL NOT produce a response after reset releases.
REQ-022 The first cycle after release SHALL arbitrate from requester 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release, all req_valid = 1 reads to distinct addresses -> cycle 1: grant 0 (A) and 1 (B); cycle 2: grant 2 (A) and 3 (B); rr_ptr returns to 0.
- Requester 2 writes 0xDEAD_BEEF to addr 5, then reads addr 5 -> rsp_valid[2] one cycle after the read grant, with rsp_rdata = 0xDEAD_BEEF.
- Requester 0 writes addr 3 while requester 1 reads addr 3 in the same cycle -> only 0 granted. Next cycle, 1 is granted and reads back the new data.
- Requesters 1 and 3 both read addr 7 in the same cycle -> both granted on ports A and B; both rsp_valid next cycle with identical data.
- Requester 1 holds valid continuously, others sparse -> no requester waits more than 2 cycles when NUM_REQ = 4.
- Read accepted, then rst_n pulsed low mid-cycle -> rsp_valid stays 0 through and after reset, and rr_ptr = 0.
